// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types, dimensions and hex keymap for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } state_e;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  // Indexed {row, col}: r0 1 2 3 A | r1 4 5 6 B | r2 7 8 9 C | r3 E 0 F D
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col_drive);
    if (!col_drive[0])      return 2'd0;
    else if (!col_drive[1]) return 2'd1;
    else if (!col_drive[2]) return 2'd2;
    else                    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix and key-event signals between the scanner and its neighbours.
interface keypad_scan_debounce_if;
  logic [keypad_pkg::NUM_ROWS-1:0] row_keys;
  logic [keypad_pkg::NUM_COLS-1:0] col_keys;
  logic                            key_valid;
  logic [3:0]                      key_code;
  logic                            key_held;

  modport slave (
    input  row_keys,
    output col_keys,
    output key_valid,
    output key_code,
    output key_held
  );

  modport master (
    output row_keys,
    input  col_keys,
    input  key_valid,
    input  key_code,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_debounce_keymap.sv
// Combinational row/column index to hex code lookup.
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] code_o
);

  assign code_o = KEYMAP[{row_i, col_i}];

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner/debouncer: one FSM, column frozen while a key is held.
// Optional auto-repeat while held when KEY_REPEAT_EN is defined.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 48000,
  parameter int unsigned DEBOUNCE_CYCLES = 960000,
  parameter int unsigned REPEAT_CYCLES   = 12000000
) (
  input  logic                   clk,
  input  logic                   reset,
  keypad_scan_debounce_if.slave  kp
);

  localparam int unsigned BASE_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                      : DEBOUNCE_CYCLES;
`ifdef KEY_REPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_CYCLES > BASE_MAX) ? REPEAT_CYCLES : BASE_MAX;
`else
  localparam int unsigned CNT_MAX = BASE_MAX;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("keypad_scan_debounce: cycle parameters must be >= 2");
  end

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_COLS-1:0] col_q;
  logic [1:0]          row_sel_q;
  logic [3:0]          code_q;
  logic                valid_q;
  logic                held_q;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0]    rep_q;
`endif

  logic [3:0] map_code;
  logic [1:0] col_idx;
  logic [1:0] first_row;
  logic       any_low;
  logic       row_low;

  assign any_low   = (kp.row_keys != 4'hF);
  assign first_row = first_low_row(kp.row_keys);
  assign row_low   = ~kp.row_keys[row_sel_q];
  assign col_idx   = col_index(col_q);

  keypad_keymap u_keymap (
    .row_i  (row_sel_q),
    .col_i  (col_idx),
    .code_o (map_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      col_q     <= 4'b1110;
      row_sel_q <= 2'd0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          // rows are only trusted once the column has settled for the full dwell
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if (any_low) begin
              row_sel_q <= first_row;
              state_q   <= DEBOUNCE_PRESS;
            end else begin
              col_q <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DEBOUNCE_PRESS: begin
          if (!row_low) begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            code_q  <= map_code;
            valid_q <= 1'b1;
            held_q  <= 1'b1;
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        HELD: begin
          if (!row_low) begin
            cnt_q   <= '0;
            state_q <= DEBOUNCE_RELEASE;
`ifdef KEY_REPEAT_EN
            rep_q   <= '0;
          end else if (rep_q == REP_LAST) begin
            rep_q   <= '0;
            valid_q <= 1'b1;
          end else begin
            rep_q <= rep_q + 1'b1;
`endif
          end
        end

        DEBOUNCE_RELEASE: begin
          if (row_low) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            col_q   <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign kp.col_keys  = col_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_held  = held_q;

endmodule
